// File: rtl/systolic_result_drain.sv
// systolic_result_drain
// Captures the N x N result matrix from the systolic array on a one-cycle
// pulse and streams it out row by row over valid/ready (row 0 first).
// A new matrix may be captured on the same cycle as the last-row handshake,
// which keeps the output stream free of bubbles. A pulse that arrives while
// a drain is still busy is discarded and flagged on the sticky drop_err.
//
//  state    | meaning
//  ---------+------------------------------------------------------------
//  ST_IDLE  | buffer holds nothing to send; any in_valid pulse is captured
//  ST_DRAIN | presenting buffer[row_ptr] on m_data, waiting for handshakes
module systolic_result_drain #(
  parameter int N = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [N-1:0][N-1:0][31:0] in_c,
  output logic                      in_ready,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [N-1:0][31:0]        m_data,
  output logic [$clog2(N)-1:0]      m_row,
  output logic                      m_last,
  output logic                      drop_err,
  input  logic                      err_clr
);

  localparam int ROW_W = $clog2(N);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(N - 1);

  logic [0:0]                state_q;
  logic [ROW_W-1:0]          row_ptr_q;
  logic [N-1:0][N-1:0][31:0] buf_q;
  logic                      drop_err_q;

  logic handshake;
  logic capture;
  logic drop;

  assign m_valid   = (state_q == ST_DRAIN);
  assign m_row     = row_ptr_q;
  assign m_last    = m_valid & (row_ptr_q == LAST_ROW);
  // In IDLE this still shows the last row sent; consumers ignore it, but it
  // stays deterministic because the buffer is only written on capture.
  assign m_data    = buf_q[row_ptr_q];
  assign in_ready  = (state_q == ST_IDLE) | (m_last & m_ready);
  assign handshake = m_valid & m_ready;
  assign capture   = in_valid & in_ready;
  assign drop      = in_valid & ~in_ready;
  assign drop_err  = drop_err_q;

  // Sequencing: capture a matrix, then walk row_ptr over it one handshake at a time
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      row_ptr_q <= '0;
      buf_q     <= '0;
    end else if (capture) begin
      buf_q     <= in_c;
      row_ptr_q <= '0;
      state_q   <= ST_DRAIN;
    end else if (handshake) begin
      if (row_ptr_q == LAST_ROW) begin
        state_q <= ST_IDLE;
      end else begin
        row_ptr_q <= row_ptr_q + 1'b1;
      end
    end
  end

  // Sticky drop flag; a new drop wins over a simultaneous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_err_q <= 1'b0;
    end else if (drop) begin
      drop_err_q <= 1'b1;
    end else if (err_clr) begin
      drop_err_q <= 1'b0;
    end
  end

endmodule
